// File: rtl/ibex_masked_register_file_pkg.sv
// Shared types and constants for the masked register file and its rekey walk.
// The writeback-stage masking encoder uses the same reset key.
package ibex_masked_register_file_pkg;

    typedef enum logic {
        RF_REKEY_IDLE,
        RF_REKEY_WALK
    } rf_rekey_state_e;

    localparam logic [31:0] RF_MASK_KEY_RESET = 32'h52068860;

endpackage

// File: rtl/ibex_masked_register_file_if.sv
// Register-file bus: two read ports, writeback write port, and key handshake.
// The master is the core side; the slave is the register file.
interface ibex_masked_register_file_if
    import ibex_masked_register_file_pkg::*;
#(
    parameter int DataWidth = 32
);
    logic [4:0]           raddr_a_i;
    logic [DataWidth-1:0] rdata_a_o;
    logic [4:0]           raddr_b_i;
    logic [DataWidth-1:0] rdata_b_o;
    logic [4:0]           waddr_a_i;
    logic [DataWidth-1:0] wdata_a_i;
    logic                 we_a_i;
    logic                 wmask_a_i;
    logic [DataWidth-1:0] key_i;
    logic                 key_valid_i;
    logic                 key_ready_o;
    logic                 busy_o;
    logic                 rekey_done_o;

    modport master (
        output raddr_a_i, raddr_b_i, waddr_a_i, wdata_a_i, we_a_i, wmask_a_i,
               key_i, key_valid_i,
        input  rdata_a_o, rdata_b_o, key_ready_o, busy_o, rekey_done_o
    );

    modport slave (
        input  raddr_a_i, raddr_b_i, waddr_a_i, wdata_a_i, we_a_i, wmask_a_i,
               key_i, key_valid_i,
        output rdata_a_o, rdata_b_o, key_ready_o, busy_o, rekey_done_o
    );
endinterface

// File: rtl/ibex_masked_register_file_rekey_ctrl.sv
// Key handshake and rekey walk sequencer: owns the live key, the pending key
// and the walk index that the storage array uses to re-mask tagged registers.
module ibex_masked_register_file_rekey_ctrl
    import ibex_masked_register_file_pkg::*;
#(
    parameter int                   NumRegs   = 32,
    parameter int                   DataWidth = 32,
    parameter logic [DataWidth-1:0] KeyReset  = DataWidth'(RF_MASK_KEY_RESET)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DataWidth-1:0] key_i,
    input  logic                 key_valid_i,
    output logic                 key_ready_o,
    output logic                 busy_o,
    output logic                 rekey_done_o,
    output logic [4:0]           cnt_o,
    output logic                 walk_en_o,
    output logic [DataWidth-1:0] key_q_o,
    output logic [DataWidth-1:0] key_new_q_o
);
    localparam logic [4:0] LastIdx = 5'(NumRegs - 1);

    rf_rekey_state_e      state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [DataWidth-1:0] key_q, key_d, key_new_q, key_new_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RF_REKEY_IDLE;
            cnt_q     <= '0;
            key_q     <= KeyReset;
            key_new_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            key_new_q <= key_new_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        key_d        = key_q;
        key_new_d    = key_new_q;
        rekey_done_o = 1'b0;
        unique case (state_q)
            RF_REKEY_IDLE: begin
                if (key_valid_i) begin
                    key_new_d = key_i;
                    cnt_d     = 5'd1;
                    state_d   = RF_REKEY_WALK;
                end
            end
            RF_REKEY_WALK: begin
                // The last register's step and the key swap share one edge.
                if (cnt_q == LastIdx) begin
                    rekey_done_o = 1'b1;
                    key_d        = key_new_q;
                    cnt_d        = '0;
                    state_d      = RF_REKEY_IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
        endcase
    end

    assign key_ready_o = (state_q == RF_REKEY_IDLE);
    assign busy_o      = (state_q == RF_REKEY_WALK);
    assign walk_en_o   = busy_o;
    assign cnt_o       = cnt_q;
    assign key_q_o     = key_q;
    assign key_new_q_o = key_new_q;

endmodule

// File: rtl/ibex_masked_register_file.sv
// Register file that stores masked writeback data with a per-register tag and
// presents plaintext on both read ports, including while a rekey walk runs.
module ibex_masked_register_file
    import ibex_masked_register_file_pkg::*;
#(
    parameter bit                   RV32E     = 1'b0,
    parameter int                   DataWidth = 32,
    parameter logic [DataWidth-1:0] KeyReset  = DataWidth'(RF_MASK_KEY_RESET)
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    ibex_masked_register_file_if.slave rf
);
    localparam int NumRegs = RV32E ? 16 : 32;
    localparam int AddrW   = RV32E ? 4 : 5;

    logic [4:0]           cnt;
    logic                 walk_en;
    logic [DataWidth-1:0] key_q, key_new_q, key_x;
    logic [AddrW-1:0]     waddr_idx;

    logic [NumRegs-1:0][DataWidth-1:0] rdata_plain;

    ibex_masked_register_file_rekey_ctrl #(
        .NumRegs  (NumRegs),
        .DataWidth(DataWidth),
        .KeyReset (KeyReset)
    ) u_rekey_ctrl (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .key_i       (rf.key_i),
        .key_valid_i (rf.key_valid_i),
        .key_ready_o (rf.key_ready_o),
        .busy_o      (rf.busy_o),
        .rekey_done_o(rf.rekey_done_o),
        .cnt_o       (cnt),
        .walk_en_o   (walk_en),
        .key_q_o     (key_q),
        .key_new_q_o (key_new_q)
    );

    // XOR-ing with both keys moves a word from the old key to the new one.
    assign key_x       = key_q ^ key_new_q;
    assign waddr_idx   = rf.waddr_a_i[AddrW-1:0];
    assign rdata_plain[0] = '0;

    for (genvar i = 1; i < NumRegs; i++) begin : g_reg
        logic [DataWidth-1:0] mem_q;
        logic                 tag_q;
        logic                 wr_hit, step_hit, walked;

        assign wr_hit   = rf.we_a_i && (waddr_idx == AddrW'(i));
        assign walked   = walk_en && (5'(i) < cnt);
        assign step_hit = walk_en && (cnt == 5'(i)) && tag_q && !wr_hit;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                mem_q <= '0;
                tag_q <= 1'b0;
            end else if (wr_hit) begin
                // Registers the walk has passed already live under the new key.
                mem_q <= (walk_en && rf.wmask_a_i && (5'(i) <= cnt)) ?
                         rf.wdata_a_i ^ key_x : rf.wdata_a_i;
                tag_q <= rf.wmask_a_i;
            end else if (step_hit) begin
                mem_q <= mem_q ^ key_x;
            end
        end

        assign rdata_plain[i] = tag_q ? mem_q ^ (walked ? key_new_q : key_q) : mem_q;
    end

    assign rf.rdata_a_o = rdata_plain[rf.raddr_a_i[AddrW-1:0]];
    assign rf.rdata_b_o = rdata_plain[rf.raddr_b_i[AddrW-1:0]];

    if (AddrW < 5) begin : g_unused_addr
        logic unused_addr;
        assign unused_addr = ^{rf.raddr_a_i[4:AddrW], rf.raddr_b_i[4:AddrW],
                               rf.waddr_a_i[4:AddrW]};
    end

endmodule

// File: tb/tb_ibex_masked_register_file.sv
// Bench for the masked register file: directed steps plus random traffic
// compared against a plaintext register model that tracks the live key.
module tb_ibex_masked_register_file;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    ibex_masked_register_file_if #(.DataWidth(32)) rf_bus ();
    ibex_masked_register_file_if #(.DataWidth(32)) rfe_bus ();

    ibex_masked_register_file #(.RV32E(1'b0)) dut (
        .clk_i (clk_i), .rst_ni(rst_ni), .rf(rf_bus)
    );
    ibex_masked_register_file #(.RV32E(1'b1)) dut_e (
        .clk_i (clk_i), .rst_ni(rst_ni), .rf(rfe_bus)
    );

    localparam logic [31:0] KRST = 32'h52068860;

    // Model: plaintext contents, key in force for masked writes, pending walk.
    logic [31:0] model [32];
    logic [31:0] mkey, pend;
    int walk_left;
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = '0;
        mkey = KRST;
        pend = '0;
        walk_left = 0;
    endtask

    task automatic tick();
        logic acc, we, wm;
        logic [31:0] k, wd;
        logic [4:0] wa;
        acc = rf_bus.key_valid_i && (walk_left == 0);
        k = rf_bus.key_i;  we = rf_bus.we_a_i;  wa = rf_bus.waddr_a_i;
        wd = rf_bus.wdata_a_i;  wm = rf_bus.wmask_a_i;
        @(posedge clk_i); #1;
        if (we && wa != 5'd0) model[wa] = wm ? wd ^ mkey : wd;
        if (walk_left > 0) begin
            walk_left--;
            if (walk_left == 0) mkey = pend;
        end else if (acc) begin
            walk_left = 31;
            pend = k;
        end
    endtask

    task automatic check_ports(input string tag);
        chk({tag, "_busy"},  32'(rf_bus.busy_o),       32'(walk_left > 0));
        chk({tag, "_ready"}, 32'(rf_bus.key_ready_o),  32'(walk_left == 0));
        chk({tag, "_done"},  32'(rf_bus.rekey_done_o), 32'(walk_left == 1));
        chk({tag, "_rda"},   rf_bus.rdata_a_o, model[rf_bus.raddr_a_i]);
        chk({tag, "_rdb"},   rf_bus.rdata_b_o, model[rf_bus.raddr_b_i]);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic m);
        rf_bus.we_a_i = 1'b1; rf_bus.waddr_a_i = a; rf_bus.wdata_a_i = d; rf_bus.wmask_a_i = m;
        #1; tick();
        rf_bus.we_a_i = 1'b0; rf_bus.wmask_a_i = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        rf_bus.raddr_a_i = a;
        #1;
        chk(tag, rf_bus.rdata_a_o, exp);
        chk({tag, "_model"}, rf_bus.rdata_a_o, model[a]);
    endtask

    initial begin
        int busy_cnt, done_at;
        rf_bus.raddr_a_i = '0; rf_bus.raddr_b_i = '0; rf_bus.waddr_a_i = '0;
        rf_bus.wdata_a_i = '0; rf_bus.we_a_i = 1'b0; rf_bus.wmask_a_i = 1'b0;
        rf_bus.key_i = '0; rf_bus.key_valid_i = 1'b0;
        rfe_bus.raddr_a_i = '0; rfe_bus.raddr_b_i = '0; rfe_bus.waddr_a_i = '0;
        rfe_bus.wdata_a_i = '0; rfe_bus.we_a_i = 1'b0; rfe_bus.wmask_a_i = 1'b0;
        rfe_bus.key_i = '0; rfe_bus.key_valid_i = 1'b0;
        model_reset();

        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        rf_bus.raddr_a_i = 5'd1; rf_bus.raddr_b_i = 5'd31;
        #1;
        chk("reset_x1", rf_bus.rdata_a_o, 32'h0);
        chk("reset_x31", rf_bus.rdata_b_o, 32'h0);
        check_ports("reset");

        wr(5'd1, 32'h52068864, 1'b1);
        rd_chk("x1_masked", 5'd1, 32'h00000004);
        wr(5'd2, 32'h00000004, 1'b0);
        rd_chk("x2_plain", 5'd2, 32'h00000004);
        wr(5'd0, 32'hDEADBEEF, 1'b0);
        rd_chk("x0_hardwired", 5'd0, 32'h0);

        // Walk under key FFFF0000 with writes ahead of, on and behind the index.
        rf_bus.raddr_a_i = 5'd1;
        rf_bus.key_i = 32'hFFFF0000; rf_bus.key_valid_i = 1'b1;
        #1; tick();
        rf_bus.key_valid_i = 1'b0;
        busy_cnt = 0; done_at = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            rf_bus.we_a_i = 1'b0; rf_bus.wmask_a_i = 1'b0;
            if (cyc == 3) begin
                rf_bus.we_a_i = 1'b1; rf_bus.wmask_a_i = 1'b1;
                rf_bus.waddr_a_i = 5'd5; rf_bus.wdata_a_i = 32'h12345678 ^ KRST;
            end else if (cyc == 7) begin
                rf_bus.we_a_i = 1'b1; rf_bus.wmask_a_i = 1'b1;
                rf_bus.waddr_a_i = 5'd7; rf_bus.wdata_a_i = 32'h0A0B0C0D ^ KRST;
            end else if (cyc == 9) begin
                rf_bus.we_a_i = 1'b1; rf_bus.wmask_a_i = 1'b1;
                rf_bus.waddr_a_i = 5'd2; rf_bus.wdata_a_i = 32'hCAFEF00D ^ KRST;
            end
            rf_bus.raddr_b_i = 5'($urandom_range(0, 31));
            #1;
            if (rf_bus.busy_o) begin
                busy_cnt++;
                chk("walk_x1", rf_bus.rdata_a_o, 32'h00000004);
            end
            if (rf_bus.rekey_done_o) done_at = cyc;
            check_ports("walk");
            tick();
        end
        rf_bus.we_a_i = 1'b0; rf_bus.wmask_a_i = 1'b0;
        chk("walk_len", busy_cnt, 31);
        chk("walk_done_cycle", done_at, 31);
        chk("walk_ready_after", 32'(rf_bus.key_ready_o), 32'd1);
        rd_chk("ahead_x5", 5'd5, 32'h12345678);
        rd_chk("same_x7", 5'd7, 32'h0A0B0C0D);
        rd_chk("behind_x2", 5'd2, 32'hCAFEF00D);
        wr(5'd3, 32'hFFFF0001, 1'b1);
        rd_chk("newkey_x3", 5'd3, 32'h00000001);

        // Random traffic with occasional key offers.
        for (int n = 0; n < 300; n++) begin
            rf_bus.we_a_i = 1'($urandom_range(0, 1));
            rf_bus.waddr_a_i = 5'($urandom);
            rf_bus.wdata_a_i = $urandom;
            rf_bus.wmask_a_i = 1'($urandom_range(0, 1));
            rf_bus.key_valid_i = ($urandom_range(0, 15) == 0);
            rf_bus.key_i = $urandom;
            rf_bus.raddr_a_i = 5'($urandom);
            rf_bus.raddr_b_i = 5'($urandom);
            #1;
            check_ports("rand");
            tick();
        end
        rf_bus.we_a_i = 1'b0; rf_bus.key_valid_i = 1'b0;
        while (walk_left > 0) tick();

        // Reset in the middle of a walk.
        rf_bus.key_i = 32'h13579BDF; rf_bus.key_valid_i = 1'b1;
        #1; tick();
        rf_bus.key_valid_i = 1'b0;
        repeat (9) tick();
        rst_ni = 1'b0;
        model_reset();
        #1;
        chk("rst_busy", 32'(rf_bus.busy_o), 32'd0);
        chk("rst_ready", 32'(rf_bus.key_ready_o), 32'd1);
        for (int i = 0; i < 32; i++) begin
            rf_bus.raddr_a_i = 5'(i); rf_bus.raddr_b_i = 5'(31 - i);
            #1;
            chk("rst_rda", rf_bus.rdata_a_o, 32'h0);
            chk("rst_rdb", rf_bus.rdata_b_o, 32'h0);
        end
        @(posedge clk_i); #1 rst_ni = 1'b1;
        wr(5'd4, KRST ^ 32'h000000AB, 1'b1);
        rd_chk("rst_key", 5'd4, 32'h000000AB);

        // RV32E: upper address bit ignored, 15-cycle walk.
        rfe_bus.we_a_i = 1'b1; rfe_bus.waddr_a_i = 5'd18; rfe_bus.wdata_a_i = 32'h7;
        #1; tick();
        rfe_bus.we_a_i = 1'b0;
        rfe_bus.raddr_a_i = 5'd2; rfe_bus.raddr_b_i = 5'd18;
        #1;
        chk("e_alias_a", rfe_bus.rdata_a_o, 32'h7);
        chk("e_alias_b", rfe_bus.rdata_b_o, 32'h7);
        rfe_bus.key_i = 32'hFFFF0000; rfe_bus.key_valid_i = 1'b1;
        #1; tick();
        rfe_bus.key_valid_i = 1'b0;
        busy_cnt = 0; done_at = -1;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            #1;
            if (rfe_bus.busy_o) busy_cnt++;
            if (rfe_bus.rekey_done_o) done_at = cyc;
            tick();
        end
        chk("e_walk_len", busy_cnt, 15);
        chk("e_done_cycle", done_at, 15);
        chk("e_ready_after", 32'(rfe_bus.key_ready_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ibex_masked_register_file.md
Name: ibex_masked_register_file

Overview:
- Register file that receives writeback-stage writes. Those writes may carry data XOR-masked with a masking key (JAL link values).
- Keeps a per-register "masked" tag and unmasks data on the read ports, so ID/EX always sees plaintext. It is the decoder for the writeback-side encoder.
- Supports runtime key replacement: a rekey walk re-masks every tagged register under the new key.
- Sits between the writeback stage (write port) and ID/EX (two read ports), replacing the plain flop register file.

Parameters:
- RV32E, 0, 1 selects 16 registers (NumRegs=16), otherwise 32.
- DataWidth, 32, register width in bits.
- KeyReset, 32'h52068860, masking key value after reset.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- raddr_a_i  in  5  read port A address
- rdata_a_o  out  DataWidth  read port A plaintext data
- raddr_b_i  in  5  read port B address
- rdata_b_o  out  DataWidth  read port B plaintext data
- waddr_a_i  in  5  write address (from writeback stage)
- wdata_a_i  in  DataWidth  write data, masked when wmask_a_i=1
- we_a_i  in  1  write enable
- wmask_a_i  in  1  write data is XOR-masked with the current key
- key_i  in  DataWidth  new masking key
- key_valid_i  in  1  new key offered
- key_ready_o  out  1  key accepted when valid&ready
- busy_o  out  1  rekey walk in progress
- rekey_done_o  out  1  one-cycle pulse on the last walk cycle

Behaviour:
- State: mem_q[1..NumRegs-1], tag_q[1..NumRegs-1], key_q, key_new_q, cnt_q (5 bit), FSM {IDLE, REKEY}.
- x0 is hardwired to 0 with tag 0. Writes to x0 are dropped; reads of x0 return 0.
- Address bits above NumRegs-1 are ignored (RV32E uses addr[3:0]).
- Reset values: mem=0, tag=0, key_q=KeyReset, key_new_q=0, cnt=0, state IDLE, key_ready_o=1, busy_o=0, rekey_done_o=0. rdata outputs are therefore 0.
- Reset mid-walk aborts immediately to the reset state and discards key_new_q.
- Reads are combinational.
  - rdata = tag[i] ? mem[i] ^ k(i) : mem[i].
  - k(i) = key_new_q if (state==REKEY and i < cnt_q), else key_q.
  - There is no write-to-read bypass: a write is visible on the cycle after the write edge.
- Write in IDLE (we_a_i=1, addr!=0): mem <= wdata_a_i and tag <= wmask_a_i, latched at the clock edge.
- Key handshake:
  - key_ready_o = (state==IDLE).
  - On accept: key_new_q <= key_i, cnt_q <= 1, state <= REKEY.
  - key_valid_i while busy is ignored; the key is held by the source until ready.
- REKEY, every cycle:
  - If tag[cnt] is set and there is no write to cnt this cycle, mem[cnt] <= mem[cnt] ^ key_q ^ key_new_q.
  - Then cnt_q++.
  - When cnt_q == NumRegs-1: perform that step, assert rekey_done_o, key_q <= key_new_q, state <= IDLE, cnt_q <= 0.
  - The walk lasts exactly NumRegs-1 cycles (31, or 15 for RV32E).
  - busy_o = (state==REKEY).
  - A new key equal to key_q still runs the full walk.
- Writes during REKEY are always accepted; the core is not stalled.
  - wmask=0: mem <= wdata, tag <= 0.
  - wmask=1 and index > cnt_q: mem <= wdata (still under the old key, walk converts it later), tag <= 1.
  - wmask=1 and index <= cnt_q: mem <= wdata ^ key_q ^ key_new_q, tag <= 1.
  - A write to index == cnt_q wins over the walk step for that register.
- Key acceptance and a write in the same cycle: the write is treated as an IDLE write (old key).
- Simultaneous reads of any registers are always allowed; reading the register being walked returns correct plaintext both before and after its step.

Decomposition:
- ibex_pkg gains rf_rekey_state_e {RF_REKEY_IDLE, RF_REKEY_WALK} and the constant RF_MASK_KEY_RESET = 32'h52068860. The writeback-stage masking constant uses the same constant.
- One natural sub-module: ibex_masked_rf_rekey_ctrl. It holds the FSM, cnt_q, key_q/key_new_q and the handshake, and exports cnt, walk-enable, key_q and key_new_q to the storage array in the top module.

Test Plan:
- After reset, read x1/x31 -> 0. key_ready_o=1, busy_o=0.
- Write x1 = 32'h52068864 with wmask=1, then read x1 -> 32'h00000004. Write x2 = 32'h00000004 with wmask=0, then read x2 -> 32'h00000004.
- With x1 tagged, offer key 32'hFFFF0000:
  - busy_o high for exactly 31 cycles; rekey_done_o pulses on the 31st.
  - x1 reads 32'h00000004 on every cycle of the walk.
  - Afterwards key_ready_o=1, and writing x3 = 32'hFFFF0001 with wmask=1 reads back 32'h00000001.
- During a walk, masked writes (data = value ^ 32'h52068860):
  - to x5 at cnt=3 (ahead of the walk) -> reads correct after the walk;
  - to x2 at cnt=9 (behind the walk) -> reads correct after the walk;
  - to x7 at cnt=7 (same cycle as its step) -> reads correct after the walk.
  - In all cases the readback is the unmasked value, e.g. 32'h12345678.
- Write x0 = 32'hDEADBEEF -> reads 0. RV32E=1: walk length is 15 cycles.
- Assert rst_ni low at cnt=10 -> busy_o=0 at once, key_ready_o=1, all registers read 0, key back to 32'h52068860.
